// File: rtl/fifo_write_packer.sv
// fifo_write_packer: packs RATIO narrow beats (LSB-first) into one FIFO word and writes it,
// throttled by the FIFO's registered wrfull.
//   aclr          async active-high reset
//   wrclk         write-domain clock
//   in_valid/in_data/in_last/in_ready   narrow source stream
//   fifo_wrreq/fifo_data/fifo_wrfull    FIFO write port
//   words_written saturating count of FIFO writes
//   pkt_done      pulse on the write of a packet's final word
// Optional: define FIFO_WRITE_PACKER_FLUSH_EN so that in_last on a partial word
// forces completion with zero padding.
module fifo_write_packer #(
    parameter int IN_WIDTH  = 2,
    parameter int RATIO     = 4,
    parameter int OUT_WIDTH = IN_WIDTH * RATIO,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 aclr,
    input  logic                 wrclk,
    input  logic                 in_valid,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic                 fifo_wrreq,
    output logic [OUT_WIDTH-1:0] fifo_data,
    input  logic                 fifo_wrfull,
    output logic [CNT_WIDTH-1:0] words_written,
    output logic                 pkt_done
);
    localparam int CW = $clog2(RATIO);
    localparam logic [CW-1:0] LAST_IDX = CW'(RATIO - 1);
    logic [OUT_WIDTH-1:0] acc, out_reg, merged;
    logic [CW-1:0] cnt;
    logic out_valid, out_last, complete, accept;
`ifdef FIFO_WRITE_PACKER_FLUSH_EN
    assign complete = (cnt == LAST_IDX) | in_last;
`else
    assign complete = cnt == LAST_IDX;
`endif
    assign fifo_wrreq = out_valid & ~fifo_wrfull;
    assign fifo_data  = out_reg;
    assign pkt_done   = fifo_wrreq & out_last;
    // a completing beat needs the holding stage empty or draining this cycle
    assign in_ready   = ~complete | ~out_valid | fifo_wrreq;
    assign accept     = in_valid & in_ready;
    // slots above cnt are still zero, which gives the flush zero padding for free
    always_comb begin
        merged = acc;
        merged[cnt*IN_WIDTH +: IN_WIDTH] = in_data;
    end
    always_ff @(posedge wrclk or posedge aclr) begin
        if (aclr) begin
            acc           <= '0;
            cnt           <= '0;
            out_reg       <= '0;
            out_valid     <= 1'b0;
            out_last      <= 1'b0;
            words_written <= '0;
        end else begin
            if (accept) begin
                acc <= complete ? '0 : merged;
                cnt <= complete ? '0 : cnt + 1'b1;
            end
            if (accept && complete) begin
                out_reg   <= merged;
                out_valid <= 1'b1;
                out_last  <= in_last;
            end else if (fifo_wrreq) begin
                out_valid <= 1'b0;
            end
            if (fifo_wrreq && !(&words_written))
                words_written <= words_written + 1'b1;
        end
    end
endmodule

// File: tb/tb_fifo_write_packer.sv
// tb_fifo_write_packer: randomized and directed bench against a queue-based reference model.
module tb_fifo_write_packer;
    localparam int IW = 2;
    localparam int R  = 4;
    localparam int OW = IW * R;
`ifdef FIFO_WRITE_PACKER_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif
    logic wrclk = 1'b0, aclr = 1'b1;
    logic in_valid = 1'b0, in_last = 1'b0, fifo_wrfull = 1'b0;
    logic [IW-1:0] in_data = '0;
    logic in_ready, fifo_wrreq, pkt_done;
    logic [OW-1:0] fifo_data;
    logic [15:0] words_written;
    logic s_ready, s_wrreq, s_done;
    logic [OW-1:0] s_data;
    logic [1:0] ww_sat;
    int n_cmp = 0, n_bad = 0;
    typedef struct packed {logic [OW-1:0] d; logic l;} w_t;
    logic [IW-1:0] part[$];
    w_t q[$];
    int exp_ww = 0;
    logic [OW-1:0] last_data = '0;

    always #5 wrclk = ~wrclk;

    fifo_write_packer #(.IN_WIDTH(IW), .RATIO(R), .CNT_WIDTH(16)) dut (
        .aclr(aclr), .wrclk(wrclk), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .fifo_wrreq(fifo_wrreq), .fifo_data(fifo_data),
        .fifo_wrfull(fifo_wrfull), .words_written(words_written), .pkt_done(pkt_done));

    fifo_write_packer #(.IN_WIDTH(IW), .RATIO(R), .CNT_WIDTH(2)) dut_sat (
        .aclr(aclr), .wrclk(wrclk), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(s_ready), .fifo_wrreq(s_wrreq), .fifo_data(s_data),
        .fifo_wrfull(fifo_wrfull), .words_written(ww_sat), .pkt_done(s_done));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic v, input logic [IW-1:0] d, input logic l, input logic f);
        logic comp, er, ew;
        w_t w;
        in_valid = v; in_data = d; in_last = l; fifo_wrfull = f;
        #1;
        comp = (part.size() == R - 1) || (FLUSH && l);
        ew   = (q.size() != 0) && !f;
        er   = !comp || (q.size() == 0) || !f;
        check("in_ready", in_ready, er);
        check("fifo_wrreq", fifo_wrreq, ew);
        check("words_written", words_written, exp_ww);
        check("sat_count", ww_sat, exp_ww > 3 ? 3 : exp_ww);
        check("sat_wrreq", s_wrreq, ew);
        if (ew) begin
            check("fifo_data", fifo_data, q[0].d);
            check("pkt_done", pkt_done, q[0].l);
            last_data = fifo_data;
            void'(q.pop_front());
            exp_ww++;
        end else begin
            check("pkt_done_idle", pkt_done, 1'b0);
        end
        if (v && er) begin
            part.push_back(d);
            if (comp) begin
                w.d = '0;
                foreach (part[k]) w.d |= OW'(part[k]) << (k * IW);
                w.l = l;
                q.push_back(w);
                part.delete();
            end
        end
        @(negedge wrclk);
    endtask

    task automatic reset_pulse();
        aclr = 1'b1; in_valid = 1'b0; in_last = 1'b0; fifo_wrfull = 1'b0;
        #1;
        check("rst_ready", in_ready, 1'b1);
        check("rst_wrreq", fifo_wrreq, 1'b0);
        check("rst_count", words_written, 0);
        check("rst_data", fifo_data, 0);
        check("rst_pkt_done", pkt_done, 1'b0);
        @(negedge wrclk);
        @(negedge wrclk);
        aclr = 1'b0;
        part.delete(); q.delete(); exp_ww = 0;
    endtask

    initial begin
        @(negedge wrclk);
        reset_pulse();
        step(1, 1, 0, 0); step(1, 2, 0, 0); step(1, 3, 0, 0); step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        check("dir_0x39", last_data, 8'h39);
        check("dir_count1", words_written, 1);
        for (int i = 0; i < 32; i++) step(1, IW'($urandom), 0, 0);
        step(0, 0, 0, 0);
        check("stream_count", words_written, 9);
        for (int i = 0; i < 10; i++) step(1, IW'($urandom), 0, 1);
        for (int i = 0; i < 6; i++) step(1, IW'($urandom), 0, 0);
        reset_pulse();
        step(1, 3, 0, 0); step(1, 3, 1, 0); step(0, 0, 0, 0);
`ifdef FIFO_WRITE_PACKER_FLUSH_EN
        check("flush_0x0F", last_data, 8'h0F);
`else
        check("noflush_count", words_written, 0);
        step(1, 1, 0, 0); step(1, 1, 0, 0); step(0, 0, 0, 0);
        check("noflush_0x5F", last_data, 8'h5F);
`endif
        reset_pulse();
        step(1, 3, 0, 0); step(1, 2, 0, 0);
        reset_pulse();
        step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        check("rst_mid_0x40", last_data, 8'h40);
        check("rst_mid_count", words_written, 1);
        reset_pulse();
        for (int i = 0; i < 20; i++) step(1, IW'($urandom), 0, 0);
        step(0, 0, 0, 0);
        check("sat_hold3", ww_sat, 2'd3);
        check("five_writes", words_written, 5);
        for (int i = 0; i < 2000; i++)
            step($urandom_range(0, 9) < 7, IW'($urandom), $urandom_range(0, 4) == 0,
                 $urandom_range(0, 9) < 3);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fifo_write_packer.md
# fifo_write_packer

Write-side width packer feeding the dual-clock FIFO in the `wrclk` domain. It accepts a narrow valid/ready stream and assembles `RATIO` beats into one `IN_WIDTH*RATIO`-bit word. It drives the FIFO's `wrreq`/`data` and throttles the source from the FIFO's registered `wrfull`, so the FIFO never overflows even when its own overflow checking is compiled out.

## Interface
- `IN_WIDTH`, 2: width of one input beat.
- `RATIO`, 4: beats per FIFO word; ≥2, power of two.
- `OUT_WIDTH`, `IN_WIDTH*RATIO`: FIFO word width; must equal the FIFO `WIDTH`.
- `CNT_WIDTH`, 16: width of the `words_written` counter.

Ports:
- `aclr`  in  1  reset; asynchronous, active-high.
- `wrclk`  in  1  clock; all logic is on the rising edge.
- `in_valid`  in  1  source beat valid.
- `in_data`  in  `IN_WIDTH`  source beat.
- `in_last`  in  1  final beat of a packet.
- `in_ready`  out  1  beat accepted when `in_valid & in_ready`.
- `fifo_wrreq`  out  1  to FIFO `wrreq`.
- `fifo_data`  out  `OUT_WIDTH`  to FIFO `data`.
- `fifo_wrfull`  in  1  from FIFO `wrfull`.
- `words_written`  out  `CNT_WIDTH`  saturating count of FIFO writes.
- `pkt_done`  out  1  one-cycle pulse on the FIFO write of a packet's final word.

## Operation
- State:
  - `acc`: `OUT_WIDTH` accumulator.
  - `cnt`: beat index, `log2(RATIO)` bits.
  - `out_reg`, `out_valid`, `out_last`: output holding stage.
  - `words_written`.
- Packing is LSB-first: the beat accepted at index k lands in `acc[k*IN_WIDTH +: IN_WIDTH]`.
- Accept and `cnt < RATIO-1`: write the beat into `acc`, then `cnt` increments.
- Accept and `cnt == RATIO-1` (word complete):
  - `out_reg` ← `acc` with the current beat merged.
  - `out_valid` ← 1, `out_last` ← `in_last`.
  - `cnt` ← 0, `acc` ← 0.
- Output stage:
  - `fifo_wrreq = out_valid & ~fifo_wrfull` (combinational).
  - `fifo_data = out_reg`.
  - `out_valid` clears on the write edge unless a new word loads on the same edge.
- `in_ready = (cnt != RATIO-1) | ~out_valid | fifo_wrreq`. A completing beat is accepted only if the holding stage is free or draining in the same cycle.
- Simultaneous drain and load: the old word is written and the new word loads on the same edge, so `out_valid` stays 1. This sustains full throughput of one word per `RATIO` cycles.
- `in_last` on a completing beat tags the word; `pkt_done` pulses on that word's write cycle (`fifo_wrreq & out_last`). Handling of `in_last` on a non-completing beat is covered under Configuration.
- `words_written`:
  - increments on every `fifo_wrreq` cycle;
  - saturates at all-ones.
- FIFO full:
  - `fifo_wrreq` is held low and `out_reg` is held;
  - `in_ready` drops once `cnt == RATIO-1`;
  - no beat is lost or duplicated.
- `fifo_wrfull` is registered in the FIFO with look-ahead, so combinational gating on it is sufficient.

## Timing
- Reset values: `acc`=0, `cnt`=0, `out_valid`=0, `out_last`=0, `words_written`=0, `fifo_wrreq`=0, `pkt_done`=0, `fifo_data`=0. `in_ready`=1 while `aclr` is high and after reset.
- Latency: a word-completing beat is accepted at edge E; `fifo_wrreq` is high in the cycle after E (if not full), and the FIFO writes at E+1.
- Reset mid-packet discards the partial `acc` and any pending `out_reg`. No `fifo_wrreq` is generated during or after reset until new beats complete a word.
- `cnt` wraps from RATIO-1 to 0. There is no other wrap-around state.

## Configuration
- `FIFO_WRITE_PACKER_FLUSH_EN` defined:
  - `in_last` accepted with `cnt < RATIO-1` forces word completion;
  - unfilled upper beats are zero-padded;
  - `out_last` = 1, `cnt` ← 0;
  - `in_ready` on that beat follows the completing-beat rule.
- Undefined:
  - `in_last` is honoured only on completing beats and is otherwise ignored;
  - partial words wait for further beats;
  - `pkt_done` fires only for packets whose length is a multiple of `RATIO`.

## Test plan
- Parameters for all scenarios: `RATIO`=4, `IN_WIDTH`=2.
- Beats 1,2,3,0 back-to-back with `fifo_wrfull`=0 → one `fifo_wrreq` cycle with `fifo_data`=0x39, one cycle after the 4th accept; `words_written`=1.
- Continuous `in_valid` for 32 beats, FIFO never full → 8 writes, `in_ready` constantly 1, data in order.
- `fifo_wrfull`=1 held for 10 cycles while streaming → `fifo_wrreq`=0 and `in_ready` low after the next word completes. On release: exactly one write of the held word next cycle, no lost or duplicated beats.
- Beats 3,3 with `in_last` on the 2nd, macro defined → `fifo_data`=0x0F and `pkt_done` pulses. Macro undefined → no write; following beats 1,1 produce 0x5F.
- `aclr` pulse after 2 beats, then beats 0,0,0,1 → single write of 0x40; the pre-reset beats do not appear.
- Force `words_written` near all-ones via `CNT_WIDTH`=2 and make 5 writes → the count holds at 3.
